// File: rtl/wb_sdram_arbiter.sv
// Two-master Wishbone B4 classic arbiter in front of the SDRAM controller slave port.
// Round-robin per cycle, lock while owner cyc is held, watchdog terminates stuck accesses with err.
module wb_sdram_arbiter #(
    parameter int DW      = 32,
    parameter int AW      = 26,
    parameter int TIMEOUT = 256
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              sdr_init_done,

    input  logic              m0_cyc_i,
    input  logic              m0_stb_i,
    input  logic              m0_we_i,
    input  logic [DW/8-1:0]   m0_sel_i,
    input  logic [AW-1:0]     m0_adr_i,
    input  logic [DW-1:0]     m0_dat_i,
    output logic [DW-1:0]     m0_dat_o,
    output logic              m0_ack_o,
    output logic              m0_err_o,

    input  logic              m1_cyc_i,
    input  logic              m1_stb_i,
    input  logic              m1_we_i,
    input  logic [DW/8-1:0]   m1_sel_i,
    input  logic [AW-1:0]     m1_adr_i,
    input  logic [DW-1:0]     m1_dat_i,
    output logic [DW-1:0]     m1_dat_o,
    output logic              m1_ack_o,
    output logic              m1_err_o,

    output logic              s_cyc_o,
    output logic              s_stb_o,
    output logic              s_we_o,
    output logic [DW/8-1:0]   s_sel_o,
    output logic [AW-1:0]     s_adr_o,
    output logic [DW-1:0]     s_dat_o,
    input  logic [DW-1:0]     s_dat_i,
    input  logic              s_ack_i,

    output logic [1:0]        gnt_o
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN  = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic            owner_r;
    logic            owner_nxt_s;
    logic            last_owner_r;
    logic            last_owner_nxt_s;
    logic            err_first_r;
    logic            err_first_nxt_s;
    logic [CW-1:0]   count_r;
    logic [CW-1:0]   count_nxt_s;

    logic            own_cyc_s;
    logic            own_stb_s;
    logic            own_we_s;
    logic [DW/8-1:0] own_sel_s;
    logic [AW-1:0]   own_adr_s;
    logic [DW-1:0]   own_dat_s;
    logic            wd_fire_s;

    // Select the current owner's request signals
    always_comb begin
        own_cyc_s = 1'b0;
        own_stb_s = 1'b0;
        own_we_s  = 1'b0;
        own_sel_s = {(DW/8){1'b0}};
        own_adr_s = {AW{1'b0}};
        own_dat_s = {DW{1'b0}};
        if (owner_r) begin
            own_cyc_s = m1_cyc_i;
            own_stb_s = m1_stb_i;
            own_we_s  = m1_we_i;
            own_sel_s = m1_sel_i;
            own_adr_s = m1_adr_i;
            own_dat_s = m1_dat_i;
        end else begin
            own_cyc_s = m0_cyc_i;
            own_stb_s = m0_stb_i;
            own_we_s  = m0_we_i;
            own_sel_s = m0_sel_i;
            own_adr_s = m0_adr_i;
            own_dat_s = m0_dat_i;
        end
    end

    // Slave-side forwarding; outputs are also forced low while reset is asserted
    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_sel_o = {(DW/8){1'b0}};
        s_adr_o = {AW{1'b0}};
        s_dat_o = {DW{1'b0}};
        if (!wb_rst_i && (state_r == ST_OWN)) begin
            s_cyc_o = own_cyc_s;
            s_stb_o = own_stb_s;
            s_we_o  = own_we_s;
            s_sel_o = own_sel_s;
            s_adr_o = own_adr_s;
            s_dat_o = own_dat_s;
        end else begin
            s_cyc_o = 1'b0;
        end
    end

    assign wd_fire_s = (count_r == CW'(TIMEOUT - 1)) && s_stb_o && !s_ack_i;

    // Master-side responses: ack only while owning, err only on the first ERR cycle
    always_comb begin
        gnt_o    = 2'b00;
        m0_ack_o = 1'b0;
        m1_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m1_err_o = 1'b0;
        m0_dat_o = {DW{1'b0}};
        m1_dat_o = {DW{1'b0}};
        if (!wb_rst_i) begin
            m0_dat_o = s_dat_i;
            m1_dat_o = s_dat_i;
            if (state_r != ST_IDLE) begin
                gnt_o = owner_r ? 2'b10 : 2'b01;
            end else begin
                gnt_o = 2'b00;
            end
            if (state_r == ST_OWN) begin
                m0_ack_o = s_ack_i && !owner_r;
                m1_ack_o = s_ack_i &&  owner_r;
            end else begin
                m0_ack_o = 1'b0;
                m1_ack_o = 1'b0;
            end
            if ((state_r == ST_ERR) && err_first_r) begin
                m0_err_o = !owner_r;
                m1_err_o =  owner_r;
            end else begin
                m0_err_o = 1'b0;
                m1_err_o = 1'b0;
            end
        end else begin
            gnt_o = 2'b00;
        end
    end

    // Arbitration FSM next-state, ownership bookkeeping and watchdog counter
    always_comb begin
        state_nxt_s      = state_r;
        owner_nxt_s      = owner_r;
        last_owner_nxt_s = last_owner_r;
        err_first_nxt_s  = 1'b0;
        count_nxt_s      = {CW{1'b0}};
        case (state_r)
            ST_IDLE: begin
                if (sdr_init_done && (m0_cyc_i || m1_cyc_i)) begin
                    state_nxt_s = ST_OWN;
                    if (m0_cyc_i && m1_cyc_i) begin
                        owner_nxt_s = ~last_owner_r;
                    end else begin
                        owner_nxt_s = m1_cyc_i;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_OWN: begin
                if (!own_cyc_s) begin
                    state_nxt_s      = ST_IDLE;
                    last_owner_nxt_s = owner_r;
                end else if (wd_fire_s) begin
                    state_nxt_s     = ST_ERR;
                    err_first_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = ST_OWN;
                end
                if (s_ack_i || !s_stb_o) begin
                    count_nxt_s = {CW{1'b0}};
                end else begin
                    count_nxt_s = count_r + CW'(1);
                end
            end
            ST_ERR: begin
                if (!own_cyc_s) begin
                    state_nxt_s      = ST_IDLE;
                    last_owner_nxt_s = owner_r;
                end else begin
                    state_nxt_s = ST_ERR;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_r      <= ST_IDLE;
            owner_r      <= 1'b0;
            last_owner_r <= 1'b1;
            err_first_r  <= 1'b0;
            count_r      <= {CW{1'b0}};
        end else begin
            state_r      <= state_nxt_s;
            owner_r      <= owner_nxt_s;
            last_owner_r <= last_owner_nxt_s;
            err_first_r  <= err_first_nxt_s;
            count_r      <= count_nxt_s;
        end
    end

endmodule

// File: tb/tb_wb_sdram_arbiter.sv
// Self-checking bench for wb_sdram_arbiter: arbitration vector table plus hand-written
// sequences for bursts, turnaround, watchdog timeout and mid-transfer reset.
module tb_wb_sdram_arbiter;

    localparam int DW = 32;
    localparam int AW = 26;
    localparam int TO = 8;

    logic            clk = 1'b0;
    logic            wb_rst_i, sdr_init_done;
    logic            m0_cyc_i, m0_stb_i, m0_we_i, m1_cyc_i, m1_stb_i, m1_we_i;
    logic [DW/8-1:0] m0_sel_i, m1_sel_i, s_sel_o;
    logic [AW-1:0]   m0_adr_i, m1_adr_i, s_adr_o;
    logic [DW-1:0]   m0_dat_i, m1_dat_i, m0_dat_o, m1_dat_o, s_dat_o, s_dat_i;
    logic            m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
    logic            s_cyc_o, s_stb_o, s_we_o, s_ack_i;
    logic [1:0]      gnt_o;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic          init;
        logic          c0;
        logic          c1;
        logic [1:0]    gnt;
        logic [AW-1:0] adr;
    } vec_t;
    vec_t vecs[5];

    typedef struct {
        logic          we;
        logic [AW-1:0] adr;
        logic [DW-1:0] dat;
    } exp_t;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    wb_sdram_arbiter #(.DW(DW), .AW(AW), .TIMEOUT(TO)) dut (
        .wb_clk_i(clk), .wb_rst_i(wb_rst_i), .sdr_init_done(sdr_init_done),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o),
        .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o),
        .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
        .gnt_o(gnt_o)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive_m(input int m, input logic cyc, input logic stb, input logic we,
                           input logic [AW-1:0] adr, input logic [DW-1:0] dat);
        if (m == 0) begin
            m0_cyc_i = cyc; m0_stb_i = stb; m0_we_i = we;
            m0_sel_i = stb ? 4'hF : 4'h0; m0_adr_i = adr; m0_dat_i = dat;
        end else begin
            m1_cyc_i = cyc; m1_stb_i = stb; m1_we_i = we;
            m1_sel_i = stb ? 4'hF : 4'h0; m1_adr_i = adr; m1_dat_i = dat;
        end
    endtask

    task automatic do_reset(input logic init);
        wb_rst_i = 1'b1;
        sdr_init_done = init;
        s_ack_i = 1'b0;
        s_dat_i = 32'h0;
        drive_m(0, 1'b0, 1'b0, 1'b0, 26'h0, 32'h0);
        drive_m(1, 1'b0, 1'b0, 1'b0, 26'h0, 32'h0);
        adv();
        adv();
        wb_rst_i = 1'b0;
    endtask

    // One stb/ack beat by the current owner m; slave acks after 'waits' stalled cycles
    task automatic beat(input int m, input logic we, input logic [AW-1:0] adr,
                        input logic [DW-1:0] wdat, input int waits, input logic [DW-1:0] rdat);
        exp_t e;
        drive_m(m, 1'b1, 1'b1, we, adr, wdat);
        e.we = we; e.adr = adr; e.dat = we ? wdat : rdat;
        sb_q.push_back(e);
        for (int i = 0; i < waits; i++) begin
            settle();
            chk("wait_no_ack", {m1_ack_o, m0_ack_o}, 2'b00);
            chk("wait_gnt", gnt_o, (m == 1) ? 2'b10 : 2'b01);
            if (we) chk("wait_s_dat", s_dat_o, wdat);
            adv();
        end
        s_ack_i = 1'b1;
        s_dat_i = rdat;
        settle();
        chk("ack_route", {m1_ack_o, m0_ack_o}, (m == 1) ? 2'b10 : 2'b01);
        e = sb_q.pop_front();
        chk("s_adr", s_adr_o, e.adr);
        chk("s_we", s_we_o, e.we);
        if (e.we) chk("s_dat", s_dat_o, e.dat);
        else      chk("m_dat", (m == 1) ? m1_dat_o : m0_dat_o, e.dat);
        adv();
        s_ack_i = 1'b0;
        drive_m(m, 1'b1, 1'b0, we, adr, wdat);
        settle();
        chk("ack_drop", {m1_ack_o, m0_ack_o}, 2'b00);
    endtask

    initial begin
        vecs[0] = '{init: 1'b0, c0: 1'b1, c1: 1'b1, gnt: 2'b00, adr: 26'h0};
        vecs[1] = '{init: 1'b1, c0: 1'b0, c1: 1'b0, gnt: 2'b00, adr: 26'h0};
        vecs[2] = '{init: 1'b1, c0: 1'b1, c1: 1'b0, gnt: 2'b01, adr: 26'h111};
        vecs[3] = '{init: 1'b1, c0: 1'b0, c1: 1'b1, gnt: 2'b10, adr: 26'h222};
        vecs[4] = '{init: 1'b1, c0: 1'b1, c1: 1'b1, gnt: 2'b01, adr: 26'h111};

        // Reset values
        do_reset(1'b1);
        wb_rst_i = 1'b1;
        settle();
        chk("rst_gnt", gnt_o, 2'b00);
        chk("rst_s_bus", {s_cyc_o, s_stb_o, s_we_o}, 3'b000);
        chk("rst_resp", {m0_ack_o, m0_err_o, m1_ack_o, m1_err_o}, 4'b0000);
        chk("rst_dat", {m0_dat_o, m1_dat_o}, 64'h0);
        adv();
        wb_rst_i = 1'b0;

        // Arbitration table, fresh reset per vector
        foreach (vecs[k]) begin
            do_reset(vecs[k].init);
            drive_m(0, vecs[k].c0, vecs[k].c0, 1'b0, 26'h111, 32'h0);
            drive_m(1, vecs[k].c1, vecs[k].c1, 1'b0, 26'h222, 32'h0);
            settle();
            chk("rel_stb_low", s_stb_o, 1'b0);
            adv();
            settle();
            chk("tbl_gnt", gnt_o, vecs[k].gnt);
            chk("tbl_adr", s_adr_o, vecs[k].adr);
        end

        // Grants held off until init completes
        do_reset(1'b0);
        drive_m(0, 1'b1, 1'b1, 1'b0, 26'h123, 32'h0);
        for (int i = 0; i < 20; i++) begin
            settle();
            chk("init_hold", {gnt_o, s_cyc_o}, 3'b000);
            adv();
        end
        sdr_init_done = 1'b1;
        adv();
        settle();
        chk("init_gnt", gnt_o, 2'b01);
        chk("init_adr", s_adr_o, 26'h123);

        // m0 single write, slave acks three cycles after stb
        do_reset(1'b1);
        drive_m(0, 1'b1, 1'b0, 1'b1, 26'h100, 32'hDEADBEEF);
        adv();
        beat(0, 1'b1, 26'h100, 32'hDEADBEEF, 3, 32'h0);
        drive_m(0, 1'b0, 1'b0, 1'b0, 26'h0, 32'h0);
        adv();
        settle();
        chk("wr_idle", gnt_o, 2'b00);

        // Round robin and one idle turnaround cycle
        do_reset(1'b1);
        drive_m(0, 1'b1, 1'b0, 1'b0, 26'h10, 32'h0);
        drive_m(1, 1'b1, 1'b0, 1'b0, 26'h20, 32'h0);
        adv();
        settle();
        chk("rr_first", gnt_o, 2'b01);
        beat(0, 1'b1, 26'h10, 32'h11111111, 0, 32'h0);
        drive_m(0, 1'b0, 1'b0, 1'b0, 26'h0, 32'h0);
        adv();
        settle();
        chk("rr_turnaround", {gnt_o, s_cyc_o}, 3'b000);
        adv();
        settle();
        chk("rr_second", gnt_o, 2'b10);
        beat(1, 1'b1, 26'h20, 32'h22222222, 0, 32'h0);
        drive_m(1, 1'b0, 1'b0, 1'b0, 26'h0, 32'h0);
        adv();
        drive_m(0, 1'b1, 1'b0, 1'b0, 26'h10, 32'h0);
        drive_m(1, 1'b1, 1'b0, 1'b0, 26'h20, 32'h0);
        adv();
        settle();
        chk("rr_third", gnt_o, 2'b01);

        // m1 locked 4-beat read burst while m0 waits
        do_reset(1'b1);
        drive_m(1, 1'b1, 1'b0, 1'b0, 26'h200, 32'h0);
        adv();
        settle();
        chk("burst_gnt", gnt_o, 2'b10);
        drive_m(0, 1'b1, 1'b1, 1'b0, 26'h50, 32'h0);
        for (int i = 0; i < 4; i++) begin
            beat(1, 1'b0, AW'(32'h200 + i), 32'h0, 1, 32'hA5A50000 + i);
        end
        drive_m(1, 1'b0, 1'b0, 1'b0, 26'h0, 32'h0);
        adv();
        settle();
        chk("burst_release", gnt_o, 2'b00);
        adv();
        settle();
        chk("burst_m0_gnt", gnt_o, 2'b01);

        // Watchdog: no ack for TIMEOUT stb cycles
        do_reset(1'b1);
        drive_m(0, 1'b1, 1'b1, 1'b0, 26'h300, 32'h0);
        adv();
        for (int i = 0; i < TO; i++) begin
            settle();
            chk("wd_stb", {s_stb_o, m0_err_o}, 2'b10);
            adv();
        end
        settle();
        chk("wd_err", {m0_err_o, m1_err_o}, 2'b10);
        chk("wd_bus_off", {s_cyc_o, s_stb_o}, 2'b00);
        s_ack_i = 1'b1;
        settle();
        chk("wd_late_ack", {m0_ack_o, m1_ack_o}, 2'b00);
        adv();
        settle();
        chk("wd_err_once", {m0_err_o, m0_ack_o}, 2'b00);
        s_ack_i = 1'b0;
        drive_m(0, 1'b0, 1'b0, 1'b0, 26'h0, 32'h0);
        adv();
        settle();
        chk("wd_idle", gnt_o, 2'b00);

        // Reset asserted mid-transfer
        do_reset(1'b1);
        drive_m(1, 1'b1, 1'b1, 1'b0, 26'h2A0, 32'h0);
        adv();
        settle();
        chk("mid_gnt", gnt_o, 2'b10);
        adv();
        wb_rst_i = 1'b1;
        s_ack_i = 1'b1;
        settle();
        chk("mid_rst_stb", s_stb_o, 1'b0);
        chk("mid_rst_ack", m1_ack_o, 1'b0);
        adv();
        settle();
        chk("mid_rst_bus", {gnt_o, s_cyc_o}, 3'b000);
        wb_rst_i = 1'b0;
        s_ack_i = 1'b0;
        drive_m(0, 1'b1, 1'b1, 1'b0, 26'h2B0, 32'h0);
        settle();
        chk("mid_rel_stb", s_stb_o, 1'b0);
        adv();
        settle();
        chk("mid_regrant", gnt_o, 2'b01);

        chk("sb_empty", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
